mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial memory port shared by icache fills and the load/store unit
// Reads see one cycle of memory latency; stores to the UART window wait while its buffer is full.
module mem_arbiter #(
  parameter int FILL_LEN = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        clear_in,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [7:0]  ic_byte,
  output logic        ic_byte_valid,
  output logic        ic_done,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_done
);
  typedef enum logic [2:0] {IDLE, IC_READ, LS_READ, LS_WRITE, IO_WAIT} state_t;

  state_t      state, state_d;
  logic [31:0] base, base_d;
  logic [31:0] wdata, wdata_d;
  logic [31:0] acc, acc_d;
  logic [8:0]  nbytes, nbytes_d;
  logic [9:0]  cnt, cnt_d;
  logic        rr_ic, rr_ic_d;
  logic [7:0]  mem_dout_d, ic_byte_d;
  logic [31:0] mem_a_d, lsb_rdata_d;
  logic        mem_wr_d, ic_byte_valid_d, ic_done_d, lsb_done_d;

  logic [8:0]  ls_len;
  logic [1:0]  rd_idx;
  logic [31:0] next_a;
  logic        grant_ls, grant_ic;

  // rr_ic set means the icache wins the next tie
  assign grant_ls = lsb_req && (!ic_req || !rr_ic);
  assign grant_ic = ic_req && !grant_ls;
  assign next_a   = base + {22'd0, cnt};
  // cnt counts edges since acceptance; the byte landing now was addressed two edges ago
  assign rd_idx   = cnt[1:0] - 2'd2;

  always_comb begin
    case (lsb_size)
      2'd0:    ls_len = 9'd1;
      2'd1:    ls_len = 9'd2;
      default: ls_len = 9'd4;
    endcase
  end

  always_comb begin
    state_d         = state;
    base_d          = base;
    wdata_d         = wdata;
    acc_d           = acc;
    nbytes_d        = nbytes;
    cnt_d           = cnt;
    rr_ic_d         = rr_ic;
    mem_dout_d      = mem_dout;
    mem_a_d         = mem_a;
    mem_wr_d        = mem_wr;
    ic_byte_d       = ic_byte;
    lsb_rdata_d     = lsb_rdata;
    ic_byte_valid_d = 1'b0;
    ic_done_d       = 1'b0;
    lsb_done_d      = 1'b0;

    case (state)
      IDLE: begin
        mem_wr_d = 1'b0;
        mem_a_d  = 32'd0;
        if (!clear_in && grant_ic) begin
          state_d  = IC_READ;
          base_d   = ic_addr;
          nbytes_d = 9'(FILL_LEN);
          cnt_d    = 10'd1;
          mem_a_d  = ic_addr;
          rr_ic_d  = 1'b0;
        end else if (!clear_in && grant_ls) begin
          rr_ic_d  = 1'b1;
          base_d   = lsb_addr;
          wdata_d  = lsb_wdata;
          nbytes_d = ls_len;
          acc_d    = 32'd0;
          cnt_d    = 10'd1;
          if (!lsb_wr) begin
            state_d = LS_READ;
            mem_a_d = lsb_addr;
          end else if (lsb_addr[17:16] == 2'b11 && io_buffer_full) begin
            state_d = IO_WAIT;
          end else begin
            state_d    = LS_WRITE;
            mem_wr_d   = 1'b1;
            mem_a_d    = lsb_addr;
            mem_dout_d = lsb_wdata[7:0];
          end
        end
      end

      IC_READ, LS_READ: begin
        if (clear_in) begin
          state_d = IDLE;
          mem_a_d = 32'd0;
        end else begin
          cnt_d = cnt + 10'd1;
          if (cnt < {1'b0, nbytes}) mem_a_d = next_a;
          if (cnt >= 10'd2) begin
            if (state == IC_READ) begin
              ic_byte_d       = mem_din;
              ic_byte_valid_d = 1'b1;
            end else begin
              acc_d[{rd_idx, 3'b000} +: 8] = mem_din;
            end
          end
          if (cnt == {1'b0, nbytes} + 10'd1) begin
            state_d = IDLE;
            mem_a_d = 32'd0;
            if (state == IC_READ) begin
              ic_done_d = 1'b1;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = acc_d;
            end
          end
        end
      end

      LS_WRITE: begin
        if (cnt < {1'b0, nbytes}) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = next_a;
          mem_dout_d = wdata[{cnt[1:0], 3'b000} +: 8];
          cnt_d      = cnt + 10'd1;
        end else begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = 32'd0;
          lsb_done_d = 1'b1;
        end
      end

      IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d    = LS_WRITE;
          mem_wr_d   = 1'b1;
          mem_a_d    = base;
          mem_dout_d = wdata[7:0];
          cnt_d      = 10'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      base          <= 32'd0;
      wdata         <= 32'd0;
      acc           <= 32'd0;
      nbytes        <= 9'd0;
      cnt           <= 10'd0;
      rr_ic         <= 1'b0;
      mem_dout      <= 8'd0;
      mem_a         <= 32'd0;
      mem_wr        <= 1'b0;
      ic_byte       <= 8'd0;
      ic_byte_valid <= 1'b0;
      ic_done       <= 1'b0;
      lsb_rdata     <= 32'd0;
      lsb_done      <= 1'b0;
    end else if (rdy_in) begin
      state         <= state_d;
      base          <= base_d;
      wdata         <= wdata_d;
      acc           <= acc_d;
      nbytes        <= nbytes_d;
      cnt           <= cnt_d;
      rr_ic         <= rr_ic_d;
      mem_dout      <= mem_dout_d;
      mem_a         <= mem_a_d;
      mem_wr        <= mem_wr_d;
      ic_byte       <= ic_byte_d;
      ic_byte_valid <= ic_byte_valid_d;
      ic_done       <= ic_done_d;
      lsb_rdata     <= lsb_rdata_d;
      lsb_done      <= lsb_done_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a timeline model
// The model expands every accepted transaction into its full per-edge output schedule.
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, io_buffer_full, clear_in;
  logic        ic_req, lsb_req, lsb_wr;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout, ic_byte;
  logic [31:0] mem_a, ic_addr, lsb_addr, lsb_wdata, lsb_rdata;
  logic [1:0]  lsb_size;
  logic        mem_wr, ic_byte_valid, ic_done, lsb_done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_arbiter #(.FILL_LEN(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .clear_in(clear_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_byte(ic_byte),
    .ic_byte_valid(ic_byte_valid), .ic_done(ic_done),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // memory device (ram) and the model's own view of memory (ref_mem)
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction
  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction
  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    if (rdy_in) mem_din <= rd_ram(mem_a);
  end

  typedef struct {
    logic        wr;
    logic        achk;
    logic [31:0] a;
    logic [7:0]  dout;
    logic        bv;
    logic [7:0]  byt;
    logic        icd;
    logic        lsd;
    logic        rv;
    logic [31:0] rdata;
    logic        rd;
  } ev_t;

  ev_t         q[$];
  ev_t         cur;
  logic        io_wait, last_ic;
  logic [31:0] w_base, w_data;
  int          w_n;
  logic [7:0]  exp_byte;
  logic [31:0] exp_rdata;

  function automatic ev_t idle_ev();
    ev_t e;
    e = '{default: 0};
    e.achk = 1'b1;
    return e;
  endfunction

  task automatic push_read(input logic ic, input logic [31:0] b, input int n);
    logic [31:0] word;
    logic [7:0]  v;
    word = 32'd0;
    for (int k = 0; k <= n + 1; k++) begin
      ev_t e;
      e = '{default: 0};
      e.rd = 1'b1;
      if (k < n) begin
        e.achk = 1'b1;
        e.a = b + 32'(k);
      end
      if (k >= 2) begin
        v = rd_ref(b + 32'(k - 2));
        if (ic) begin
          e.bv = 1'b1;
          e.byt = v;
        end else begin
          word = word | (32'(v) << (8 * (k - 2)));
        end
      end
      if (k == n + 1) begin
        if (ic) e.icd = 1'b1;
        else begin
          e.lsd = 1'b1;
          e.rv = 1'b1;
          e.rdata = word;
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic push_write(input logic [31:0] b, input logic [31:0] d, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e = '{default: 0};
      e.wr = 1'b1;
      e.achk = 1'b1;
      e.a = b + 32'(i);
      e.dout = d[8 * i +: 8];
      q.push_back(e);
    end
    e = idle_ev();
    e.lsd = 1'b1;
    q.push_back(e);
  endtask

  always @(posedge clk_in) begin
    int n;
    if (rst_in) begin
      q.delete();
      io_wait = 1'b0;
      last_ic = 1'b1;
      cur = idle_ev();
      exp_byte = 8'd0;
      exp_rdata = 32'd0;
    end else if (rdy_in) begin
      if (clear_in && q.size() > 0 && q[0].rd) begin
        q.delete();
        cur = idle_ev();
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (io_wait) begin
        if (!io_buffer_full) begin
          io_wait = 1'b0;
          push_write(w_base, w_data, w_n);
          cur = q.pop_front();
        end else begin
          cur = idle_ev();
          cur.achk = 1'b0;
        end
      end else begin
        cur = idle_ev();
        if (!clear_in && (ic_req || lsb_req)) begin
          if (lsb_req && (!ic_req || last_ic)) begin
            last_ic = 1'b0;
            n = (lsb_size == 2'd0) ? 1 : (lsb_size == 2'd1) ? 2 : 4;
            if (!lsb_wr) push_read(1'b0, lsb_addr, n);
            else if (lsb_addr[17:16] == 2'b11 && io_buffer_full) begin
              io_wait = 1'b1;
              w_base = lsb_addr;
              w_data = lsb_wdata;
              w_n = n;
            end else push_write(lsb_addr, lsb_wdata, n);
          end else begin
            last_ic = 1'b1;
            push_read(1'b1, ic_addr, 16);
          end
          if (io_wait) cur.achk = 1'b0;
          else cur = q.pop_front();
        end
      end
      if (cur.wr) ref_mem[cur.a] = cur.dout;
      if (cur.bv) exp_byte = cur.byt;
      if (cur.rv) exp_rdata = cur.rdata;
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("mem_wr", mem_wr, cur.wr);
      if (cur.achk) chk("mem_a", mem_a, cur.a);
      if (cur.wr) chk("mem_dout", mem_dout, cur.dout);
      chk("ic_byte_valid", ic_byte_valid, cur.bv);
      chk("ic_byte", ic_byte, exp_byte);
      chk("ic_done", ic_done, cur.icd);
      chk("lsb_done", lsb_done, cur.lsd);
      chk("lsb_rdata", lsb_rdata, exp_rdata);
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0: return 32'($urandom % 64);
      1: return 32'hFFFF_FFF8 + 32'($urandom % 8);
      2: return 32'h0003_0000 + 32'($urandom % 8);
      default: return $urandom;
    endcase
  endfunction

  int  nv, nbad, ic_wait, ls_wait, n_ic, n_ls;
  bit  seen;

  initial begin
    rst_in = 1; rdy_in = 1; clear_in = 0; io_buffer_full = 0;
    ic_req = 0; lsb_req = 0; lsb_wr = 0; ic_addr = 0; lsb_addr = 0; lsb_size = 0; lsb_wdata = 0;
    preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
    @(negedge clk_in); @(negedge clk_in);
    cmp_en = 1'b1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", mem_dout, 32'd0);
    chk("rst_pulses", {ic_byte_valid, ic_done, lsb_done, mem_wr}, 32'd0);
    rst_in = 0;

    // word load
    lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h1000; lsb_size = 2;
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk_in);
      if (c == 1) chk("ld_a0", mem_a, 32'h1000);
      if (c == 4) chk("ld_a3", mem_a, 32'h1003);
      if (lsb_done) begin
        seen = 1;
        chk("ld_done_cycle", c, 6);
        chk("ld_rdata", lsb_rdata, 32'h4433_2211);
      end
    end
    chk("ld_seen", seen, 1);
    lsb_req = 0;
    @(negedge clk_in);

    // half store, unaligned
    lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h2001; lsb_size = 1; lsb_wdata = 32'hAABB_CCDD;
    @(negedge clk_in);
    chk("st_w0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2001, 8'hDD});
    @(negedge clk_in);
    chk("st_w1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2002, 8'hCC});
    @(negedge clk_in);
    chk("st_done", {mem_wr, lsb_done}, 2'b01);
    lsb_req = 0;
    @(negedge clk_in);
    chk("st_no_third", mem_wr, 1'b0);

    // tie after reset: LSB first, then a full icache fill
    rst_in = 1; ic_req = 1; ic_addr = 32'h4000;
    lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h1000; lsb_size = 0;
    @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    chk("rr_lsb_first", mem_a, 32'h1000);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_in);
      if (lsb_done) begin
        seen = 1;
        chk("rr_ld_rdata", lsb_rdata, 32'h11);
      end
    end
    chk("rr_lsb_done", seen, 1);
    lsb_req = 0;
    nv = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk_in);
      if (ic_byte_valid) begin
        nv++;
        if (nv == 1) chk("ic_first_byte", ic_byte, 8'h1A);
      end
      if (ic_done) begin
        seen = 1;
        chk("ic_count_at_done", nv, 16);
        chk("ic_done_with_byte", ic_byte_valid, 1'b1);
      end
    end
    chk("ic_done_seen", seen, 1);
    ic_req = 0;
    @(negedge clk_in);

    // clear mid-fill, then a load accepted one edge later
    ic_req = 1; ic_addr = 32'h5000; nv = 0;
    for (int c = 0; c < 20 && nv < 6; c++) begin
      @(negedge clk_in);
      if (ic_byte_valid) nv++;
    end
    chk("clr_reached_byte5", nv, 6);
    clear_in = 1; ic_req = 0;
    lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h1000; lsb_size = 2;
    @(negedge clk_in);
    clear_in = 0;
    chk("clr_idle", {ic_byte_valid, ic_done, mem_a}, 34'd0);
    @(negedge clk_in);
    chk("clr_next_accept", mem_a, 32'h1000);
    nbad = 0; seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk_in);
      if (ic_byte_valid || ic_done) nbad++;
      if (lsb_done) seen = 1;
    end
    chk("clr_no_ic_pulse", nbad, 0);
    chk("clr_ld_rdata", lsb_rdata, 32'h4433_2211);
    lsb_req = 0;
    @(negedge clk_in);

    // UART store held off by a full buffer
    io_buffer_full = 1; lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h0003_0000; lsb_size = 0; lsb_wdata = 32'h5E;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_in);
      chk("io_held", mem_wr, 1'b0);
    end
    io_buffer_full = 0;
    @(negedge clk_in);
    chk("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h5E});
    @(negedge clk_in);
    chk("io_done", {mem_wr, lsb_done}, 2'b01);
    lsb_req = 0;
    @(negedge clk_in);

    // reset in the middle of a load
    lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h1000; lsb_size = 2;
    repeat (3) @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0; lsb_req = 0;
    chk("mid_rst_regs", {mem_wr, mem_a, mem_dout, lsb_done}, 42'd0);
    chk("mid_rst_rdata", lsb_rdata, 32'd0);
    nbad = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (lsb_done) nbad++;
    end
    chk("mid_rst_no_done", nbad, 0);

    // randomized traffic
    ic_wait = 0; ls_wait = 0; n_ic = 0; n_ls = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_in);
      rst_in = ($urandom % 700) == 0;
      rdy_in = ($urandom % 8) != 0;
      clear_in = ($urandom % 16) == 0;
      io_buffer_full = ($urandom % 3) == 0;
      if (ic_req && ic_done) begin
        ic_req = 0;
        n_ic++;
      end else if (!ic_req && !ic_done && ($urandom % 4) == 0) begin
        ic_req = 1;
        ic_addr = rand_addr();
      end
      if (lsb_req && lsb_done) begin
        lsb_req = 0;
        n_ls++;
      end else if (!lsb_req && !lsb_done && ($urandom % 3) == 0) begin
        lsb_req = 1;
        lsb_wr = $urandom % 2;
        lsb_addr = rand_addr();
        lsb_size = 2'($urandom % 4);
        lsb_wdata = $urandom;
      end
      ic_wait = ic_req ? ic_wait + 1 : 0;
      ls_wait = lsb_req ? ls_wait + 1 : 0;
      if (ic_wait == 1500) chk("ic_watchdog", ic_wait, 0);
      if (ls_wait == 1500) chk("ls_watchdog", ls_wait, 0);
    end
    chk("ic_progress", n_ic > 0, 1);
    chk("ls_progress", n_ls > 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
